// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement adder/subtractor: processes CHUNK bits per clock,
// finishing in WIDTH/CHUNK cycles, with a valid/ready handshake on both sides.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic [WIDTH-1:0] a_q, bx_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;

  assign accept = (state_q == IDLE) && in_valid;

  // NOTE: operand registers carry no reset; they are always loaded before being
  // read, so resetting them would only add fan-out on rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      a_q  <= a;
      bx_q <= b ^ {WIDTH{m}};
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    k_d       = k_q;
    carry_d   = carry_q;
    s_d       = s_q;
    c_out_d   = c_out_q;
    v_d       = v_q;
    z_d       = z_q;
    n_d       = n_q;
    chunk_a   = a_q[k_q*CHUNK +: CHUNK];
    chunk_b   = bx_q[k_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK+1)'(carry_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          carry_d = m;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == KW'(NCHUNK - 1)) begin
          // Overflow when both MSB inputs agree but the sum's MSB differs,
          // equivalent to carry-in XOR carry-out of the top bit.
          c_out_d = chunk_sum[CHUNK];
          v_d     = (chunk_a[CHUNK-1] ~^ chunk_b[CHUNK-1])
                    & (chunk_sum[CHUNK-1] ^ chunk_a[CHUNK-1]);
          z_d     = (s_d == '0);
          n_d     = chunk_sum[CHUNK-1];
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: a 16/4 instance and an 8/8 instance,
// directed vectors with hand-computed results checked by per-instance monitors.
module tb_addsub_serial;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        m, out_ready, in_valid16, in_valid8;

  logic        ir16, ov16, c16, v16, z16, n16;
  logic [15:0] s16;
  logic        ir8, ov8, c8, v8, z8, n8;
  logic [7:0]  s8;

  logic        sel_v;
  logic        obs_ir, obs_ov, obs_c, obs_v, obs_z, obs_n;
  logic [15:0] obs_s;

  res_t q16[$], q8[$];
  res_t e16, e8;
  int   vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(ir16),
    .a(a), .b(b), .m(m), .out_valid(ov16), .out_ready(out_ready),
    .s(s16), .c_out(c16), .v(v16), .z(z16), .n(n16));

  addsub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .m(m), .out_valid(ov8), .out_ready(out_ready),
    .s(s8), .c_out(c8), .v(v8), .z(z8), .n(n8));

  assign obs_ir = sel_v ? ir8 : ir16;
  assign obs_ov = sel_v ? ov8 : ov16;
  assign obs_s  = sel_v ? {8'h00, s8} : s16;
  assign obs_c  = sel_v ? c8 : c16;
  assign obs_v  = sel_v ? v8 : v16;
  assign obs_z  = sel_v ? z8 : z16;
  assign obs_n  = sel_v ? n8 : n16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a result is consumed at the edge following a negedge that
  // sees out_valid && out_ready.
  always @(negedge clk) begin
    if (ov16 && out_ready) begin
      if (q16.size() == 0) check("q16 unexpected result", 32'd1, 32'd0);
      else begin
        e16 = q16.pop_front();
        check("w16 s", 32'(s16), 32'(e16.s));
        check("w16 c_out", 32'(c16), 32'(e16.c));
        check("w16 v", 32'(v16), 32'(e16.v));
        check("w16 z", 32'(z16), 32'(e16.z));
        check("w16 n", 32'(n16), 32'(e16.n));
      end
    end
    if (ov8 && out_ready) begin
      if (q8.size() == 0) check("q8 unexpected result", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        check("w8 s", 32'(s8), 32'(e8.s));
        check("w8 c_out", 32'(c8), 32'(e8.c));
        check("w8 v", 32'(v8), 32'(e8.v));
        check("w8 z", 32'(z8), 32'(e8.z));
        check("w8 n", 32'(n8), 32'(e8.n));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " in_ready"}, 32'(obs_ir), 32'd1);
    check({tag, " out_valid"}, 32'(obs_ov), 32'd0);
    check({tag, " s"}, 32'(obs_s), 32'd0);
    check({tag, " c_out"}, 32'(obs_c), 32'd0);
    check({tag, " v"}, 32'(obs_v), 32'd0);
    check({tag, " z"}, 32'(obs_z), 32'd1);
    check({tag, " n"}, 32'(obs_n), 32'd0);
  endtask

  // One transaction: accept, latency count, optional back-pressure hold,
  // release with a competing in_valid that must not be accepted.
  task automatic run_op(input bit sel, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tm, input int hold, input res_t e);
    int cnt;
    int lat;
    lat = sel ? 1 : 4;
    sel_v = sel;
    a = ta; b = tb_v; m = tm; out_ready = 1'b0;
    check("in_ready before accept", 32'(obs_ir), 32'd1);
    if (sel) begin q8.push_back(e); in_valid8 = 1'b1; end
    else begin q16.push_back(e); in_valid16 = 1'b1; end
    step();
    in_valid16 = 1'b0; in_valid8 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); m = ~tm;
    cnt = 0;
    while (!obs_ov && cnt < 20) begin
      check("in_ready busy", 32'(obs_ir), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      cnt++;
    end
    check("latency", 32'(cnt), 32'(lat));
    repeat (hold) begin
      check("hold out_valid", 32'(obs_ov), 32'd1);
      check("hold in_ready", 32'(obs_ir), 32'd0);
      check("hold s", 32'(obs_s), 32'(e.s));
      check("hold v", 32'(obs_v), 32'(e.v));
      a = 16'($urandom); b = 16'($urandom);
      if (sel) in_valid8 = 1'b1; else in_valid16 = 1'b1;
      step();
      in_valid16 = 1'b0; in_valid8 = 1'b0;
    end
    out_ready = 1'b1;
    if (sel) in_valid8 = 1'b1; else in_valid16 = 1'b1;
    step();
    out_ready = 1'b0; in_valid16 = 1'b0; in_valid8 = 1'b0;
    check("released out_valid", 32'(obs_ov), 32'd0);
    check("released in_ready", 32'(obs_ir), 32'd1);
    check("result retained", 32'(obs_s), 32'(e.s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; sel_v = 1'b0;
    a = 16'hAAAA; b = 16'h5555; m = 1'b0;
    in_valid16 = 1'b1; in_valid8 = 1'b1;
    step();
    step();
    check_reset_values("por16");
    sel_v = 1'b1;
    check_reset_values("por8");
    rst_n = 1'b1; in_valid16 = 1'b0; in_valid8 = 1'b0;
    step();

    //          sel   a         b         m     hold  {s, c, v, z, n}
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    run_op(1'b0, 16'h0000, 16'h0001, 1'b1, 0, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    run_op(1'b0, 16'h1234, 16'h1234, 1'b1, 0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 3, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0, 1, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0});

    // Reset during the second RUN cycle, with in_valid also high at that edge.
    sel_v = 1'b0;
    a = 16'h1111; b = 16'h2222; m = 1'b0; in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    step();
    rst_n = 1'b0; in_valid16 = 1'b1; a = 16'h4321; b = 16'h1234;
    step();
    check_reset_values("mid-run reset");
    rst_n = 1'b1; in_valid16 = 1'b0;
    step();
    check("after reset idle", 32'(ir16), 32'd1);
    check("after reset no output", 32'(ov16), 32'd0);
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 0, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0});

    run_op(1'b1, 16'h00F2, 16'h0023, 1'b0, 0, '{16'h0015, 1'b1, 1'b0, 1'b0, 1'b0});
    run_op(1'b1, 16'h007F, 16'h0080, 1'b1, 1, '{16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1});
    run_op(1'b1, 16'h0080, 16'h0080, 1'b0, 0, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0});

    step();
    check("q16 drained", 32'(q16.size()), 32'd0);
    check("q8 drained", 32'(q8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
